// File: rtl/vga_frame_display_pkg.sv
// Screen constants, types and palette for the 320x240 frame buffer shown as 640x480@60 VGA.
package vga_frame_display_pkg;
  localparam int FB_W    = 320;
  localparam int FB_H    = 240;
  localparam int FB_SIZE = FB_W * FB_H;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_TOTAL = 800;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_TOTAL = 525;

  typedef logic [16:0] fb_addr_t;
  typedef logic [2:0]  color_code_t;
  typedef logic [11:0] rgb12_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } position_t;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  // black, white, grey, blue, red, green, yellow, cyan
  localparam rgb12_t PALETTE [8] = '{12'h000, 12'hFFF, 12'h888, 12'h00F,
                                     12'hF00, 12'h0F0, 12'hFF0, 12'h0FF};

  // y*320 + x as shift-add
  function automatic fb_addr_t fb_addr(input logic [9:0] y, input logic [9:0] x);
    return ({7'd0, y} << 8) + ({7'd0, y} << 6) + {7'd0, x};
  endfunction
endpackage

// File: rtl/vga_frame_display_timing.sv
// Pixel-tick divider and 800x525 raster counters with raw sync/visible decode.
module vga_timing
  import vga_frame_display_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible,
  output logic       frame_start
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (h == 10'(H_TOTAL - 1)) begin
          h <= '0;
          v <= (v == 10'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  assign hsync_raw   = !(h >= 10'(H_VIS + H_FP) && h < 10'(H_VIS + H_FP + H_SYNC));
  assign vsync_raw   = !(v >= 10'(V_VIS + V_FP) && v < 10'(V_VIS + V_FP + V_SYNC));
  assign visible     = (h < 10'(H_VIS)) && (v < 10'(V_VIS));
  assign frame_start = tick && (h == '0) && (v == '0);
endmodule

// File: rtl/vga_frame_display.sv
// Frame buffer fed by the draw stage, cleared after reset, scanned out pixel-doubled to VGA.
module vga_frame_display
  import vga_frame_display_pkg::*;
#(
  parameter int          CLK_DIV = 2,
  parameter color_code_t BG_CODE = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  position_t   write_pos,
  input  color_code_t write_data,
  output logic        ready,
  output logic        frame_start,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);
  logic       tick, hsync_raw, vsync_raw, visible;
  logic [9:0] h, v;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk, .reset, .tick, .h, .v, .hsync_raw, .vsync_raw, .visible, .frame_start
  );

  state_t      state, state_n;
  fb_addr_t    clr_addr, clr_addr_n, wr_addr, rd_addr;
  logic        wr_en;
  color_code_t wr_data, rd_code;
  color_code_t fb [FB_SIZE];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      clr_addr <= clr_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    wr_en      = 1'b0;
    wr_addr    = clr_addr;
    wr_data    = BG_CODE;
    case (state)
      ST_CLEAR: begin
        wr_en      = 1'b1;
        clr_addr_n = clr_addr + 1'b1;
        if (clr_addr == 17'(FB_SIZE - 1)) begin
          state_n    = ST_RUN;
          clr_addr_n = '0;
        end
      end
      ST_RUN: begin
        if (write_en && write_pos.x < 10'(FB_W) && write_pos.y < 9'(FB_H)) begin
          wr_en   = 1'b1;
          wr_addr = fb_addr({1'b0, write_pos.y}, write_pos.x);
          wr_data = write_data;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state == ST_RUN);

  // Read-first RAM: the read samples the array before this clk's write lands.
  always_ff @(posedge clk) begin
    if (wr_en) fb[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (tick) rd_code <= fb[rd_addr];
  end

  logic   vis1, vis2, hs1, hs2, vs1, vs2;
  rgb12_t rgb;

  // Blanking lines would index past the buffer, so park the address at 0 there.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr <= '0;
      {vis1, vis2} <= '0;
      {hs1, hs2, vga_hsync} <= '1;
      {vs1, vs2, vga_vsync} <= '1;
      rgb <= '0;
    end else if (tick) begin
      rd_addr   <= visible ? fb_addr(v >> 1, h >> 1) : '0;
      vis1      <= visible;
      vis2      <= vis1;
      hs1       <= hsync_raw;
      hs2       <= hs1;
      vga_hsync <= hs2;
      vs1       <= vsync_raw;
      vs2       <= vs1;
      vga_vsync <= vs2;
      rgb       <= (vis2 && state == ST_RUN) ? PALETTE[rd_code] : '0;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb;
endmodule

// File: tb/tb_vga_frame_display.sv
// Directed bench: clear timing, sync widths, pixel placement, read-first and mid-frame reset.
module tb_vga_frame_display;
  import vga_frame_display_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_en = 1'b0;
  position_t   write_pos = '0;
  color_code_t write_data = '0;
  logic        ready, frame_start, vga_hsync, vga_vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  vga_frame_display dut (
    .clk(clk), .reset(reset), .write_en(write_en), .write_pos(write_pos),
    .write_data(write_data), .ready(ready), .frame_start(frame_start),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  // clk edges since reset release
  int n = 0;
  always @(posedge clk) n <= reset ? 0 : n + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic wait_n(input int k);
    while (n < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pixel p = v*800+h is on the RGB pins right after edge 2p+6
  task automatic check_pix(input string name, input int p, input logic [11:0] exp);
    wait_n(2 * p + 6);
    check(name, {vga_r, vga_g, vga_b}, exp);
  endtask

  typedef struct {
    int x;
    int y;
    int code;
  } wr_vec_t;

  typedef struct {
    int          p;
    logic [11:0] rgb;
  } pix_vec_t;

  initial begin
    #(10 * 120000);
    $display("FAIL watchdog: simulation did not finish (n=%0d)", n);
    $fatal(1, "watchdog");
  end

  initial begin
    wr_vec_t  wv [6];
    pix_vec_t pv [12];
    int hs_low, vs_low;

    wv[0] = '{0, 25, 1};
    wv[1] = '{319, 26, 4};
    wv[2] = '{100, 27, 3};
    wv[3] = '{319, 239, 4};
    wv[4] = '{320, 5, 1};
    wv[5] = '{5, 240, 2};

    pv[0]  = '{40000, 12'hFFF};
    pv[1]  = '{40001, 12'hFFF};
    pv[2]  = '{40002, 12'h000};
    pv[3]  = '{40800, 12'hFFF};
    pv[4]  = '{40801, 12'hFFF};
    pv[5]  = '{42238, 12'hF00};
    pv[6]  = '{42239, 12'hF00};
    pv[7]  = '{42300, 12'h000};
    pv[8]  = '{43037, 12'h000};
    pv[9]  = '{43039, 12'hF00};
    pv[10] = '{43400, 12'h00F};
    pv[11] = '{44201, 12'h00F};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_hsync", vga_hsync, 1);
    check("reset_vsync", vga_vsync, 1);
    check("reset_rgb", {vga_r, vga_g, vga_b}, 0);

    reset = 1'b0;
    wait_n(1);
    check("frame_start_first", frame_start, 1);
    wait_n(2);
    check("frame_start_pulse", frame_start, 0);

    hs_low = 0;
    vs_low = 0;
    for (int k = 2; k <= 1600; k++) begin
      wait_n(k);
      if (!vga_hsync) hs_low++;
      if (!vga_vsync) vs_low++;
      if (k == 1000) check("clear_black", {vga_r, vga_g, vga_b}, 0);
    end
    check("hsync_low_clks_line0", hs_low, 192);
    check("vsync_low_line0", vs_low, 0);

    wait_n(76799);
    check("ready_during_clear", ready, 0);
    wait_n(76800);
    check("ready_after_clear", ready, 1);
    check("cleared_first", dut.fb[0], 0);
    check("cleared_last", dut.fb[76799], 0);
    check_pix("run_black_v48", 38400, 12'h000);

    write_en = 1'b1;
    write_pos = '{x: 10'd0, y: 9'd0};
    write_data = 3'd7;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      write_pos.x = 10'(wv[i].x);
      write_pos.y = 9'(wv[i].y);
      write_data = 3'(wv[i].code);
      @(posedge clk);
      #1;
    end
    write_en = 1'b0;

    check("fb_origin_cyan", dut.fb[0], 7);
    check("fb_corner_red", dut.fb[76799], 4);
    check("fb_oob_x_dropped", dut.fb[1920], 0);
    check("fb_row25", dut.fb[8000], 1);

    for (int i = 0; i < 12; i++)
      check_pix($sformatf("pix_%0d", pv[i].p), pv[i].p, pv[i].rgb);

    // write fb(10,28) on the very edge that reads it for screen (20,56)
    wait_n(89643);
    write_en = 1'b1;
    write_pos = '{x: 10'd10, y: 9'd28};
    write_data = 3'd5;
    wait_n(89644);
    write_en = 1'b0;
    check_pix("read_first_old", 44820, 12'h000);
    check_pix("read_first_new_h21", 44821, 12'h0F0);
    check_pix("read_first_next_line", 45620, 12'h0F0);

    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midreset_ready", ready, 0);
    check("midreset_hsync", vga_hsync, 1);
    check("midreset_vsync", vga_vsync, 1);
    check("midreset_rgb", {vga_r, vga_g, vga_b}, 0);
    reset = 1'b0;
    wait_n(1);
    check("midreset_frame_start", frame_start, 1);
    wait_n(2);
    check("midreset_clear_restart", dut.fb[0], 0);
    check("midreset_clear_partial", dut.fb[76799], 4);
    check("midreset_ready_low", ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
